ping_scheduler: RTL and testbench

Sequences a burst of RF ping measurements. On a start pulse it fires N_PINGS transmit strobes at a fixed period and times each echo (tx_stb to rx_stb) in clock cycles. It accumulates hit count, timeout count, sum, min and max of the round-trip times, then presents one result record through a valid/ready handshake to the UART/hex-dump path. It replaces the ad-hoc process/alg/rx_counter logic in the ping top level.

---
 rtl/ping_scheduler_if.sv | 52 +++++
 rtl/ping_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ping_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ping_scheduler_if.sv
// Control and result-record bundle between ping_scheduler and the RF front end / UART dump path.
// master = the scheduler, slave = the environment that drives start, echoes and res_ready.
interface ping_scheduler_if #(
    parameter int N_PINGS = 32,
    parameter int CNT_W   = 16
);
    localparam int HIT_W = $clog2(N_PINGS + 1);
    localparam int SUM_W = CNT_W + HIT_W;

    logic             start;
    logic             busy;
    logic             tx_stb;
    logic             tx_en;
    logic             rx_stb;
    logic             res_valid;
    logic             res_ready;
    logic [HIT_W-1:0] res_hits;
    logic [HIT_W-1:0] res_timeouts;
    logic [SUM_W-1:0] res_sum;
    logic [CNT_W-1:0] res_min;
    logic [CNT_W-1:0] res_max;

    modport master (
        input  start,
        input  tx_en,
        input  rx_stb,
        input  res_ready,
        output busy,
        output tx_stb,
        output res_valid,
        output res_hits,
        output res_timeouts,
        output res_sum,
        output res_min,
        output res_max
    );

    modport slave (
        output start,
        output tx_en,
        output rx_stb,
        output res_ready,
        input  busy,
        input  tx_stb,
        input  res_valid,
        input  res_hits,
        input  res_timeouts,
        input  res_sum,
        input  res_min,
        input  res_max
    );
endinterface

// File: rtl/ping_scheduler.sv
// Burst ping sequencer: fires N_PINGS tx strobes 2^PERIOD_W cycles apart, times echoes, reports stats.
// Define PING_BLANK_EN to also ignore echoes during the first BLANK cycles after each tx_stb.
module ping_scheduler #(
    parameter int PERIOD_W = 12,
    parameter int N_PINGS  = 32,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 4000,
    parameter int BLANK    = 8
) (
    input  logic              clk,
    input  logic              rst,
    ping_scheduler_if.master  bus
);
    localparam int HIT_W = $clog2(N_PINGS + 1);
    localparam int SUM_W = CNT_W + HIT_W;
    localparam int IDX_W = (N_PINGS > 1) ? $clog2(N_PINGS) : 1;

    // The timeout must expire before the period ends so GAP always sees the period wrap.
    generate
        if (N_PINGS < 1 || TIMEOUT < 1 || TIMEOUT >= (2 ** PERIOD_W) - 1 ||
            TIMEOUT > (2 ** CNT_W) - 1 || BLANK < 0) begin : g_bad_cfg
            $error("ping_scheduler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT,
        GAP,
        REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic [PERIOD_W-1:0] period_cnt;
    logic [CNT_W-1:0]    rtt;
    logic [IDX_W-1:0]    idx;
    logic [HIT_W-1:0]    hits;
    logic [HIT_W-1:0]    timeouts;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    min_rtt;
    logic [CNT_W-1:0]    max_rtt;

    logic valid_echo;
    logic timed_out;
    logic period_end;
    logic last_ping;

`ifdef PING_BLANK_EN
    assign valid_echo = bus.rx_stb && !bus.tx_en && (rtt >= CNT_W'(BLANK));
`else
    assign valid_echo = bus.rx_stb && !bus.tx_en;
`endif
    assign timed_out  = (rtt >= CNT_W'(TIMEOUT));
    assign period_end = (period_cnt == '1);
    assign last_ping  = (idx == IDX_W'(N_PINGS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (valid_echo || timed_out) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (period_end) begin
                    state_next = last_ping ? REPORT : FIRE;
                end
            end
            REPORT: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both counters hold the number of cycles elapsed since the tx_stb cycle, so the
    // edge leaving FIRE loads 1 and an echo seen with rtt=k is exactly k cycles late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
            rtt        <= '0;
            idx        <= '0;
            hits       <= '0;
            timeouts   <= '0;
            sum        <= '0;
            min_rtt    <= '1;
            max_rtt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        period_cnt <= '0;
                        rtt        <= '0;
                        idx        <= '0;
                        hits       <= '0;
                        timeouts   <= '0;
                        sum        <= '0;
                        min_rtt    <= '1;
                        max_rtt    <= '0;
                    end
                end
                FIRE: begin
                    period_cnt <= PERIOD_W'(1);
                    rtt        <= CNT_W'(1);
                end
                WAIT: begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                    if (rtt != '1) begin
                        rtt <= rtt + CNT_W'(1);
                    end
                    if (valid_echo) begin
                        hits <= hits + HIT_W'(1);
                        sum  <= sum + SUM_W'(rtt);
                        if (rtt < min_rtt) begin
                            min_rtt <= rtt;
                        end
                        if (rtt > max_rtt) begin
                            max_rtt <= rtt;
                        end
                    end else if (timed_out) begin
                        timeouts <= timeouts + HIT_W'(1);
                    end
                end
                GAP: begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                    if (period_end && !last_ping) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                REPORT: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.tx_stb       = (state == FIRE);
    assign bus.res_valid    = (state == REPORT);
    assign bus.res_hits     = hits;
    assign bus.res_timeouts = timeouts;
    assign bus.res_sum      = sum;
    assign bus.res_min      = min_rtt;
    assign bus.res_max      = max_rtt;

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler: directed and random echo schedules against a per-ping model.
module tb_ping_scheduler;
    localparam int PERIOD_W = 6;
    localparam int N_PINGS  = 4;
    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 40;
    localparam int BLANK    = 8;
    localparam int PERIOD   = 1 << PERIOD_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ping_scheduler_if #(.N_PINGS(N_PINGS), .CNT_W(CNT_W)) bus ();

    ping_scheduler #(
        .PERIOD_W(PERIOD_W),
        .N_PINGS (N_PINGS),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .BLANK   (BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Echo schedule: per ping, per delay after tx_stb, rx_stb and tx_en levels.
    bit sched_rx [N_PINGS][PERIOD];
    bit sched_en [N_PINGS][PERIOD];

    int exp_hits;
    int exp_timeouts;
    int exp_sum;
    int exp_min;
    int exp_max;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clearSchedule();
        for (int p = 0; p < N_PINGS; p++) begin
            for (int d = 0; d < PERIOD; d++) begin
                sched_rx[p][d] = 1'b0;
                sched_en[p][d] = 1'b0;
            end
        end
    endtask

    task automatic addEcho(input int p, input int d, input bit en);
        sched_rx[p][d] = 1'b1;
        sched_en[p][d] = en;
    endtask

    // Each ping's result is the earliest qualifying echo within 1..TIMEOUT, else a loss.
    task automatic computeModel();
        bit found;
        bit blank_ok;
        exp_hits     = 0;
        exp_timeouts = 0;
        exp_sum      = 0;
        exp_min      = (1 << CNT_W) - 1;
        exp_max      = 0;
        for (int p = 0; p < N_PINGS; p++) begin
            found = 1'b0;
            for (int d = 1; d <= TIMEOUT; d++) begin
`ifdef PING_BLANK_EN
                blank_ok = (d >= BLANK);
`else
                blank_ok = 1'b1;
`endif
                if (!found && sched_rx[p][d] && !sched_en[p][d] && blank_ok) begin
                    found    = 1'b1;
                    exp_hits++;
                    exp_sum += d;
                    if (d < exp_min) exp_min = d;
                    if (d > exp_max) exp_max = d;
                end
            end
            if (!found) exp_timeouts++;
        end
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, " hits"},     bus.res_hits,     exp_hits);
        checkOutput({tag, " timeouts"}, bus.res_timeouts, exp_timeouts);
        checkOutput({tag, " sum"},      bus.res_sum,      exp_sum);
        checkOutput({tag, " min"},      bus.res_min,      exp_min);
        checkOutput({tag, " max"},      bus.res_max,      exp_max);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " busy"},      bus.busy,         0);
        checkOutput({tag, " tx_stb"},    bus.tx_stb,       0);
        checkOutput({tag, " res_valid"}, bus.res_valid,    0);
        checkOutput({tag, " hits"},      bus.res_hits,     0);
        checkOutput({tag, " timeouts"},  bus.res_timeouts, 0);
        checkOutput({tag, " sum"},       bus.res_sum,      0);
        checkOutput({tag, " min"},       bus.res_min,      16'hFFFF);
        checkOutput({tag, " max"},       bus.res_max,      0);
    endtask

    // Runs one full burst from the current schedule; all timing is counted from the start cycle.
    task automatic applyStimulus(input int hold, input bit poke_start);
        int stray_tx;
        int early_valid;
        int not_busy;
        computeModel();
        stray_tx    = 0;
        early_valid = 0;
        not_busy    = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int p = 0; p < N_PINGS; p++) begin
            checkOutput("tx_stb at period start", bus.tx_stb, 1);
            for (int d = 1; d < PERIOD; d++) begin
                @(negedge clk);
                bus.rx_stb = sched_rx[p][d];
                bus.tx_en  = sched_en[p][d];
                bus.start  = poke_start && (d == 7);
                if (bus.tx_stb)    stray_tx++;
                if (bus.res_valid) early_valid++;
                if (!bus.busy)     not_busy++;
            end
            @(negedge clk);
            bus.rx_stb = 1'b0;
            bus.tx_en  = 1'b0;
            bus.start  = 1'b0;
        end
        checkOutput("tx_stb outside period start", stray_tx, 0);
        checkOutput("res_valid before burst end", early_valid, 0);
        checkOutput("busy dropped during burst", not_busy, 0);
        checkOutput("res_valid at 1+N*period", bus.res_valid, 1);
        checkResults("report");
        repeat (hold) begin
            @(negedge clk);
            bus.rx_stb = ($urandom_range(0, 1) == 1);
        end
        bus.rx_stb = 1'b0;
        checkOutput("res_valid held", bus.res_valid, 1);
        checkOutput("busy held", bus.busy, 1);
        checkResults("held");
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        checkOutput("res_valid after accept", bus.res_valid, 0);
        checkOutput("busy after accept", bus.busy, 0);
        @(negedge clk);
        checkOutput("start at accept ignored", {bus.busy, bus.tx_stb}, 0);
        checkResults("idle");
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.tx_en     = 1'b0;
        bus.rx_stb    = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] echo at 10 on every ping");
        clearSchedule();
        for (int p = 0; p < N_PINGS; p++) addEcho(p, 10, 1'b0);
        applyStimulus(0, 1'b0);

        $display("[TB] echoes 5, 20, 12, none");
        clearSchedule();
        addEcho(0, 5, 1'b0);
        addEcho(1, 20, 1'b0);
        addEcho(2, 12, 1'b0);
        applyStimulus(0, 1'b0);

        $display("[TB] no echoes");
        clearSchedule();
        applyStimulus(0, 1'b0);

        $display("[TB] tx_en masking and blanking window");
        clearSchedule();
        addEcho(0, 3, 1'b1);
        addEcho(0, 15, 1'b0);
        addEcho(1, 4, 1'b0);
        addEcho(1, 9, 1'b0);
        addEcho(2, 9, 1'b0);
        addEcho(3, 2, 1'b1);
        applyStimulus(0, 1'b0);

        $display("[TB] echo at timeout boundary with extra pulses in gap");
        clearSchedule();
        for (int p = 0; p < N_PINGS; p++) begin
            addEcho(p, TIMEOUT, 1'b0);
            addEcho(p, TIMEOUT + 3, 1'b0);
            addEcho(p, PERIOD - 1, 1'b0);
        end
        addEcho(1, TIMEOUT + 1, 1'b0);
        sched_rx[1][TIMEOUT] = 1'b0;
        applyStimulus(0, 1'b0);

        $display("[TB] held res_ready and start during burst");
        clearSchedule();
        addEcho(0, 7, 1'b0);
        addEcho(2, 33, 1'b0);
        applyStimulus(20, 1'b1);

        $display("[TB] reset in WAIT");
        clearSchedule();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.rx_stb = 1'b1;
        @(negedge clk);
        bus.rx_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetState("async reset");
        @(negedge clk);
        rst = 1'b0;
        clearSchedule();
        addEcho(0, 11, 1'b0);
        addEcho(3, 25, 1'b0);
        applyStimulus(1, 1'b0);

        $display("[TB] random bursts");
        for (int r = 0; r < 10; r++) begin
            clearSchedule();
            for (int p = 0; p < N_PINGS; p++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        addEcho(p, $urandom_range(1, TIMEOUT), ($urandom_range(0, 3) == 0));
                    else
                        addEcho(p, $urandom_range(1, PERIOD - 1), ($urandom_range(0, 3) == 0));
                end
            end
            applyStimulus($urandom_range(0, 5), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
